// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges single-cycle ALU results and queued load results
// onto the single register-file write port. The ALU always wins. Loads wait in a
// small circular FIFO. A newer ALU write to the same register cancels any queued
// load to that register. Writes to r0 are dropped.
module writeback_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_aluValid,
    input  logic [4:0]                 i_aluAdd,
    input  logic [31:0]                i_aluData,
    input  logic                       i_ldValid,
    output logic                       o_ldReady,
    input  logic [4:0]                 i_ldAdd,
    input  logic [31:0]                i_ldData,
    output logic                       o_writeEn,
    output logic [4:0]                 o_writeAdd,
    output logic [31:0]                o_writeData,
    input  logic [4:0]                 i_checkAdd,
    output logic                       o_pending,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    // FIFO bookkeeping
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] live_q, live_d;

    // FIFO payload; no reset needed because the live bits gate all use
    logic [4:0]       add_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];

    // Output write register
    logic             wen_q, wen_d;
    logic [4:0]       wadd_q, wadd_d;
    logic [31:0]      wdata_q, wdata_d;

    // Per-entry decode
    logic [DEPTH-1:0] occupied;
    logic [DEPTH-1:0] kill;
    logic [DEPTH-1:0] hit;

    logic alu_issue;
    logic ld_ready;
    logic ld_accept;
    logic push;
    logic push_live;
    logic fifo_nonempty;
    logic head_live;
    logic pop;

    assign alu_issue     = i_aluValid & (i_aluAdd != 5'd0);
    assign ld_ready      = !i_rst & (count_q < CW'(DEPTH));
    assign ld_accept     = i_ldValid & ld_ready;
    // A load to r0 is consumed but never stored
    assign push          = ld_accept & (i_ldAdd != 5'd0);
    // A load arriving alongside an ALU write to the same register is older
    assign push_live     = !(alu_issue & (i_ldAdd == i_aluAdd));
    assign fifo_nonempty = (count_q != '0);
    assign head_live     = fifo_nonempty & live_q[head_q];
    // A dead head is always discarded; a live head only drains when the ALU is idle
    assign pop           = fifo_nonempty & (!head_live | !alu_issue);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [AW-1:0] offset;
            assign offset       = AW'(gi) - head_q;
            assign occupied[gi] = ({1'b0, offset} < count_q);
            assign kill[gi]     = alu_issue & (add_q[gi] == i_aluAdd);
            assign hit[gi]      = occupied[gi] & live_q[gi] & (add_q[gi] == i_checkAdd);
            // New entry takes its computed liveness; popped or killed entries go dead
            assign live_d[gi]   = (push && (tail_q == AW'(gi))) ? push_live :
                                  (pop  && (head_q == AW'(gi))) ? 1'b0 :
                                  kill[gi]                      ? 1'b0 :
                                                                  live_q[gi];
        end
    endgenerate

    // Pointer, occupancy and write-port selection
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        wen_d   = 1'b0;
        wadd_d  = wadd_q;
        wdata_d = wdata_q;
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (alu_issue) begin
            wen_d   = 1'b1;
            wadd_d  = i_aluAdd;
            wdata_d = i_aluData;
        end else if (head_live) begin
            wen_d   = 1'b1;
            wadd_d  = add_q[head_q];
            wdata_d = data_q[head_q];
        end
    end

    // Control state and output register, cleared immediately on reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            live_q  <= '0;
            wen_q   <= 1'b0;
            wadd_q  <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            live_q  <= live_d;
            wen_q   <= wen_d;
            wadd_q  <= wadd_d;
            wdata_q <= wdata_d;
        end
    end

    // Payload storage written at the tail on every stored load
    always_ff @(posedge i_clk) begin
        if (push) begin
            add_q[tail_q]  <= i_ldAdd;
            data_q[tail_q] <= i_ldData;
        end
    end

    assign o_ldReady   = ld_ready;
    assign o_writeEn   = wen_q;
    assign o_writeAdd  = wadd_q;
    assign o_writeData = wdata_q;
    assign o_count     = count_q;
    assign o_pending   = (i_checkAdd != 5'd0) & (|hit);

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Write-side initiator for the 32x32 register file: merges single-cycle ALU results and buffered load results onto the file's one write port (write address, write data, write enable). The ALU has fixed priority. Load results queue in a small FIFO. Writes to register 0 are discarded. A queued load is cancelled when a newer ALU write targets the same register. The block also gives issue logic a combinational "write pending" lookup for RAW stalls.

## Interface
- DEPTH, 4, load FIFO entries; power of two, ≥2
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_aluValid  in  1  ALU result present this cycle; always accepted, no ready
- i_aluAdd  in  5  ALU destination register
- i_aluData  in  32  ALU result
- i_ldValid  in  1  load result offered
- o_ldReady  out  1  FIFO can accept; transfer when i_ldValid & o_ldReady
- i_ldAdd  in  5  load destination register
- i_ldData  in  32  load data
- o_writeEn  out  1  register-file write strobe, registered
- o_writeAdd  out  5  register-file write address, registered
- o_writeData  out  32  register-file write data, registered
- i_checkAdd  in  5  register queried by issue logic
- o_pending  out  1  live queued write to i_checkAdd exists (combinational)
- o_count  out  log2(DEPTH)+1  FIFO occupancy, including killed entries

## Operation
- FIFO entry = {live, add[4:0], data[31:0]}; circular buffer with head/tail pointers that wrap modulo DEPTH.
- o_ldReady = !i_rst & (o_count < DEPTH). Readiness is never granted by a same-cycle pop.
- Push: an accepted load with i_ldAdd ≠ 0 is stored with live=1. An accepted load with i_ldAdd = 0 is consumed and dropped; count is unchanged.
- ALU issue condition: i_aluValid & i_aluAdd ≠ 0. ALU valid with address 0 is ignored and does not block the FIFO.
- Kill: on ALU issue to register X, every stored entry with add = X gets live=0. A load to X accepted in the same cycle is treated as older and is stored with live=0.
- Each cycle, the next registered write is chosen as follows:
  - ALU issue: write {aluAdd, aluData}.
  - Else, if the FIFO head is live: pop it and write {add, data}.
  - Else: o_writeEn=0.
- A killed head is popped in any cycle, including ALU-issue cycles, and never produces a write. At most one pop per cycle.
- o_pending = (i_checkAdd ≠ 0) & OR over valid entries of (live & add == i_checkAdd). The lookup does not include the write currently on the output register.
- Simultaneous push and pop: the count stays the same and both pointers advance.

## Timing
- Reset (asynchronous assert, synchronous-safe release): FIFO empty, pointers 0, o_count=0, o_writeEn=0, o_writeAdd=0, o_writeData=0, o_ldReady=0 while i_rst=1 and 1 on the first cycle after release.
- Reset asserted mid-operation discards all queued entries and any pending output write immediately. No partial write is emitted.
- ALU latency: result presented in cycle t → o_writeEn=1 with that data in cycle t+1.
- Load latency: accepted in cycle t into an empty FIFO with no ALU issue at t+1 → written in cycle t+2. There is no bypass.
- Each o_writeEn pulse lasts exactly one cycle per write. Back-to-back writes on consecutive cycles are allowed.
- Worst-case load delay is unbounded under continuous ALU issue. Starvation is accepted by design.
- o_count updates on the clock edge after a push/pop. o_pending reflects state at the start of the cycle.

## Test plan
- Reset: assert i_rst mid-stream with 3 entries queued → o_writeEn=0, o_count=0, no write of queued data after release, o_ldReady=1 one cycle after release.
- Priority: ALU {r5, 0xAAAA_0001} every cycle for 3 cycles while loads {r6,0x1},{r7,0x2} are accepted → three ALU writes to r5, then r6=0x1 and r7=0x2 in order, o_count 2→0.
- Full and wrap: with ALU idle and the FIFO pre-filled to 4 entries, hold load valid and observe o_ldReady=0 at count 4. Continue through 10 loads to r1..r10 → writes in order, one per cycle, pointers wrap, no loss or duplication.
- r0 discard: ALU {r0, 0xFFFF_FFFF} and load {r0, 0x1234} → no o_writeEn, o_count unchanged, o_pending=0 for i_checkAdd=0.
- Kill: queue load {r9, 0xDEAD}, then ALU {r9, 0xBEEF} → exactly one write to r9 = 0xBEEF. The killed entry pops silently, and o_pending(r9) drops to 0 the cycle after the ALU issue.
- Same-cycle kill: load {r3, 0x11} and ALU {r3, 0x22} in the same cycle → only r3=0x22 is written; o_count reads 1 then 0 with no write.
